// File: rtl/clk_div_pkg.sv
// Shared types and constants for divided-clock checkers.
// FSM state type, default sizing and the expected half-period helper.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      MEAS_HI,
      MEAS_LO
   } state_e;

   localparam int unsigned DEF_DIVIDE_BY  = 10;
   localparam int unsigned DEF_CNT_W      = 8;
   localparam int unsigned DEF_TIMEOUT    = 255;
   localparam int unsigned DEF_LOCK_COUNT = 4;
   localparam int unsigned ERRCNT_W       = 8;

   function automatic int unsigned half_period(input int unsigned div);
      return div / 2;
   endfunction

endpackage

// File: rtl/clk_div_edge_det.sv
// Registers a clock-synchronous level and flags its rising/falling edges.
// Ports: clk_i, rst_ni (async low), d_i level in; rise_o, fall_o one-cycle edge flags.
module clk_div_edge_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic d_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d_i;
      end
   end

   assign rise_o = d_i & ~d_q;
   assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low phase of a divided clock, tracks lock, duty errors and stalls.
// Ports: CLKIN, CDRST_N (async low), CLKDV, ERR_CLR in;
//   HIGH_LEN, LOW_LEN, PERIOD, PERIOD_VLD, LOCKED, ERR, STALL out;
//   ERR_COUNT out only when CLK_DIV_MONITOR_ERRCNT_EN is defined.
module clk_div_monitor
   import clk_div_pkg::*;
#(
   parameter int unsigned DIVIDE_BY  = DEF_DIVIDE_BY,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input  logic             CLKIN,
   input  logic             CDRST_N,
   input  logic             CLKDV,
   input  logic             ERR_CLR,
   output logic [CNT_W-1:0] HIGH_LEN,
   output logic [CNT_W-1:0] LOW_LEN,
   output logic [CNT_W:0]   PERIOD,
   output logic             PERIOD_VLD,
   output logic             LOCKED,
   output logic             ERR,
`ifdef CLK_DIV_MONITOR_ERRCNT_EN
   output logic [ERRCNT_W-1:0] ERR_COUNT,
`endif
   output logic             STALL
);

   localparam logic [CNT_W-1:0] HALF   = CNT_W'(half_period(DIVIDE_BY));
   localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [3:0]       LOCK_N = 4'(LOCK_COUNT);

   logic rise;
   logic fall;

   state_e           state_q;
   logic [CNT_W-1:0] hi_cnt_q;
   logic [CNT_W-1:0] lo_cnt_q;
   logic [CNT_W-1:0] hi_len_q;
   logic [CNT_W-1:0] lo_len_q;
   logic             done_q;
   logic [3:0]       good_q;
   logic [3:0]       good_d;
   logic [CNT_W-1:0] high_len_q;
   logic [CNT_W-1:0] low_len_q;
   logic [CNT_W:0]   period_q;
   logic             vld_q;
   logic             locked_q;
   logic             err_q;
   logic             stall_q;

   logic good_per;
   logic bad_ev;
   logic stall_ev;

   clk_div_edge_det u_edge (
      .clk_i  (CLKIN),
      .rst_ni (CDRST_N),
      .d_i    (CLKDV),
      .rise_o (rise),
      .fall_o (fall)
   );

   assign good_per = (hi_len_q == HALF) && (lo_len_q == HALF);
   assign bad_ev   = done_q && !good_per;
   assign good_d   = (good_q == LOCK_N) ? good_q : good_q + 4'd1;

   // The phase counter saturates at TIMEOUT; stall fires on the step into it.
   always_comb begin
      stall_ev = 1'b0;
      unique case (state_q)
         IDLE:    stall_ev = 1'b0;
         SYNC:    stall_ev = !rise && (hi_cnt_q == TMO_M1);
         MEAS_HI: stall_ev = !fall && (hi_cnt_q == TMO_M1);
         MEAS_LO: stall_ev = !rise && (lo_cnt_q == TMO_M1);
      endcase
   end

   always_ff @(posedge CLKIN or negedge CDRST_N) begin
      if (!CDRST_N) begin
         state_q    <= IDLE;
         hi_cnt_q   <= '0;
         lo_cnt_q   <= '0;
         hi_len_q   <= '0;
         lo_len_q   <= '0;
         done_q     <= 1'b0;
         good_q     <= '0;
         high_len_q <= '0;
         low_len_q  <= '0;
         period_q   <= '0;
         vld_q      <= 1'b0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         vld_q  <= 1'b0;

         unique case (state_q)
            IDLE: begin
               state_q  <= SYNC;
               hi_cnt_q <= '0;
            end
            // SYNC reuses hi_cnt as its timeout counter.
            SYNC: begin
               if (rise) begin
                  state_q  <= MEAS_HI;
                  hi_cnt_q <= ONE;
               end else if (hi_cnt_q != TMO) begin
                  hi_cnt_q <= hi_cnt_q + ONE;
               end
            end
            MEAS_HI: begin
               if (fall) begin
                  state_q  <= MEAS_LO;
                  lo_cnt_q <= ONE;
                  hi_len_q <= hi_cnt_q;
               end else if (hi_cnt_q != TMO) begin
                  hi_cnt_q <= hi_cnt_q + ONE;
               end
            end
            MEAS_LO: begin
               if (rise) begin
                  state_q  <= MEAS_HI;
                  hi_cnt_q <= ONE;
                  lo_len_q <= lo_cnt_q;
                  done_q   <= 1'b1;
               end else if (lo_cnt_q != TMO) begin
                  lo_cnt_q <= lo_cnt_q + ONE;
               end
            end
         endcase

         // Publish the period one cycle after the closing rise.
         if (done_q) begin
            high_len_q <= hi_len_q;
            low_len_q  <= lo_len_q;
            period_q   <= {1'b0, hi_len_q} + {1'b0, lo_len_q};
            vld_q      <= 1'b1;
            if (good_per) begin
               good_q   <= good_d;
               locked_q <= (good_d == LOCK_N);
            end else begin
               good_q   <= '0;
               locked_q <= 1'b0;
            end
         end

         // Counter left saturated so a stuck clock stalls only once per sync.
         if (stall_ev) begin
            state_q  <= SYNC;
            hi_cnt_q <= TMO;
            good_q   <= '0;
            locked_q <= 1'b0;
         end

         err_q   <= (bad_ev & locked_q) | (err_q & ~ERR_CLR);
         stall_q <= stall_ev | (stall_q & ~ERR_CLR);
      end
   end

`ifdef CLK_DIV_MONITOR_ERRCNT_EN
   logic [ERRCNT_W-1:0] errcnt_q;
   logic [ERRCNT_W-1:0] errcnt_base;
   logic [ERRCNT_W-1:0] errcnt_d;

   // Clear and increment in one cycle: the increment survives.
   always_comb begin
      errcnt_base = ERR_CLR ? '0 : errcnt_q;
      errcnt_d    = errcnt_base;
      if ((bad_ev || stall_ev) && (errcnt_base != '1)) begin
         errcnt_d = errcnt_base + 1'b1;
      end
   end

   always_ff @(posedge CLKIN or negedge CDRST_N) begin
      if (!CDRST_N) begin
         errcnt_q <= '0;
      end else begin
         errcnt_q <= errcnt_d;
      end
   end

   assign ERR_COUNT = errcnt_q;
`endif

   assign HIGH_LEN   = high_len_q;
   assign LOW_LEN    = low_len_q;
   assign PERIOD     = period_q;
   assign PERIOD_VLD = vld_q;
   assign LOCKED     = locked_q;
   assign ERR        = err_q;
   assign STALL      = stall_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized bench for clk_div_monitor against a timestamp-based reference model.
// Drives CLKDV as phase lists; checks every output each cycle plus scenario spot checks.
module tb_clk_div_monitor;

   localparam int DIV  = 10;
   localparam int CW   = 8;
   localparam int LOCK = 4;
   localparam int TMO  = 255;
   localparam int H    = DIV / 2;

   logic          CLKIN = 1'b0;
   logic          CDRST_N;
   logic          CLKDV;
   logic          ERR_CLR;
   logic [CW-1:0] HIGH_LEN;
   logic [CW-1:0] LOW_LEN;
   logic [CW:0]   PERIOD;
   logic          PERIOD_VLD;
   logic          LOCKED;
   logic          ERR;
   logic          STALL;
`ifdef CLK_DIV_MONITOR_ERRCNT_EN
   logic [7:0]    ERR_COUNT;
`endif

   clk_div_monitor #(
      .DIVIDE_BY  (DIV),
      .CNT_W      (CW),
      .LOCK_COUNT (LOCK),
      .TIMEOUT    (TMO)
   ) dut (
      .CLKIN      (CLKIN),
      .CDRST_N    (CDRST_N),
      .CLKDV      (CLKDV),
      .ERR_CLR    (ERR_CLR),
      .HIGH_LEN   (HIGH_LEN),
      .LOW_LEN    (LOW_LEN),
      .PERIOD     (PERIOD),
      .PERIOD_VLD (PERIOD_VLD),
      .LOCKED     (LOCKED),
      .ERR        (ERR),
`ifdef CLK_DIV_MONITOR_ERRCNT_EN
      .ERR_COUNT  (ERR_COUNT),
`endif
      .STALL      (STALL)
   );

   always #5 CLKIN = ~CLKIN;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: edge timestamps since reset, not phase counters.
   int  m_n;
   bit  m_prev;
   bit  m_track;
   bit  m_high;
   bit  m_sync_arm;
   int  m_t_sync;
   int  m_t_edge;
   int  m_hi_len;
   bit  m_pend;
   int  m_p_hi;
   int  m_p_lo;
   int  m_streak;
   bit  e_vld;
   bit  e_locked;
   bit  e_err;
   bit  e_stall;
   int  e_high;
   int  e_low;
   int  e_period;
   int  e_ecnt;

   function automatic void model_reset();
      m_n = 0; m_prev = 0; m_track = 0; m_high = 0;
      m_sync_arm = 0; m_t_sync = 0; m_t_edge = 0; m_hi_len = 0;
      m_pend = 0; m_p_hi = 0; m_p_lo = 0; m_streak = 0;
      e_vld = 0; e_locked = 0; e_err = 0; e_stall = 0;
      e_high = 0; e_low = 0; e_period = 0; e_ecnt = 0;
   endfunction

   function automatic void model_step(input bit v, input bit clr);
      bit rise;
      bit fall;
      bit bad;
      bit stall;
      bit was_locked;
      int base;
      rise = v && !m_prev;
      fall = !v && m_prev;
      bad = 0;
      stall = 0;
      was_locked = e_locked;
      e_vld = 0;
      if (m_pend) begin
         m_pend = 0;
         e_vld = 1;
         e_high = m_p_hi;
         e_low = m_p_lo;
         e_period = m_p_hi + m_p_lo;
         if (m_p_hi == H && m_p_lo == H) begin
            m_streak = (m_streak < LOCK) ? m_streak + 1 : LOCK;
            if (m_streak == LOCK) e_locked = 1;
         end else begin
            bad = 1;
            m_streak = 0;
            e_locked = 0;
         end
      end
      if (m_n == 0) begin
         m_track = 0;
         m_sync_arm = 1;
         m_t_sync = 0;
      end else if (!m_track) begin
         if (rise) begin
            m_track = 1; m_high = 1; m_t_edge = m_n;
         end else if (m_sync_arm && (m_n - m_t_sync == TMO)) begin
            stall = 1;
         end
      end else if (m_high) begin
         if (fall) begin
            m_hi_len = m_n - m_t_edge; m_high = 0; m_t_edge = m_n;
         end else if (m_n - m_t_edge == TMO - 1) begin
            stall = 1;
         end
      end else begin
         if (rise) begin
            m_pend = 1; m_p_hi = m_hi_len; m_p_lo = m_n - m_t_edge;
            m_high = 1; m_t_edge = m_n;
         end else if (m_n - m_t_edge == TMO - 1) begin
            stall = 1;
         end
      end
      if (stall) begin
         m_track = 0; m_sync_arm = 0; m_streak = 0; e_locked = 0;
      end
      e_err = (bad && was_locked) || (e_err && !clr);
      e_stall = stall || (e_stall && !clr);
      base = clr ? 0 : e_ecnt;
      if ((bad || stall) && base < 255) base++;
      e_ecnt = base;
      m_prev = v;
      m_n++;
   endfunction

   task automatic check_all();
      check("high_len", HIGH_LEN, e_high);
      check("low_len", LOW_LEN, e_low);
      check("period", PERIOD, e_period);
      check("period_vld", PERIOD_VLD, e_vld);
      check("locked", LOCKED, e_locked);
      check("err", ERR, e_err);
      check("stall", STALL, e_stall);
`ifdef CLK_DIV_MONITOR_ERRCNT_EN
      check("err_count", ERR_COUNT, e_ecnt);
`endif
   endtask

   task automatic check_zero(input string p);
      check({p, "_high"}, HIGH_LEN, 0);
      check({p, "_low"}, LOW_LEN, 0);
      check({p, "_period"}, PERIOD, 0);
      check({p, "_vld"}, PERIOD_VLD, 0);
      check({p, "_locked"}, LOCKED, 0);
      check({p, "_err"}, ERR, 0);
      check({p, "_stall"}, STALL, 0);
   endtask

   bit rnd_clr = 0;
   int k = 0;
   int first_vld = -1;
   int vld_cnt = 0;
   int lock_at = 0;
   int lv_high = 0;
   int lv_per = 0;
   bit lv_locked = 0;
   bit lv_err = 0;

   function automatic bit rclr();
      return rnd_clr && ($urandom_range(0, 23) == 0);
   endfunction

   task automatic step(input bit v, input bit clr);
      CLKDV = v;
      ERR_CLR = clr;
      @(posedge CLKIN);
      model_step(v, clr);
      @(negedge CLKIN);
      check_all();
      if (PERIOD_VLD) begin
         vld_cnt++;
         lv_high = int'(HIGH_LEN);
         lv_per = int'(PERIOD);
         lv_locked = LOCKED;
         lv_err = ERR;
         if (first_vld < 0) first_vld = k;
      end
      if (LOCKED && lock_at == 0) lock_at = vld_cnt;
      k++;
   endtask

   task automatic period(input int hi, input int lo, input bit clr1);
      for (int i = 0; i < hi; i++) step(1'b1, (clr1 && i == 1) || rclr());
      for (int i = 0; i < lo; i++) step(1'b0, rclr());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st_at;
      CDRST_N = 1'b0;
      CLKDV = 1'b0;
      ERR_CLR = 1'b0;
      repeat (2) @(negedge CLKIN);
      check_zero("rst");
      #2 CDRST_N = 1'b1;
      model_reset();

      // Lock on a clean 5/5 divider after a random partial phase.
      repeat ($urandom_range(1, 7)) step(1'b0, 1'b0);
      repeat (8) period(H, H, 1'b0);
      check("lock_at_vld", lock_at, LOCK);
      check("good_high", lv_high, H);
      check("good_period", lv_per, DIV);
      check("good_err", ERR, 0);

      // Duty error 6/4 while locked, then relock.
      period(6, 4, 1'b0);
      period(H, H, 1'b0);
      check("duty_high", lv_high, 6);
      check("duty_period", lv_per, 10);
      check("duty_locked", lv_locked, 0);
      check("duty_err", lv_err, 1);
      repeat (3) period(H, H, 1'b0);
      check("relock_early", LOCKED, 0);
      period(H, H, 1'b0);
      check("relock", LOCKED, 1);
      check("err_sticky", ERR, 1);
      period(H, H, 1'b1);
      check("err_clr", ERR, 0);

      // Random mix of good, bad and glitch periods with random clears.
      rnd_clr = 1;
      repeat (40) begin
         if ($urandom_range(0, 3) != 0) period(H, H, 1'b0);
         else period($urandom_range(1, 12), $urandom_range(1, 12), 1'b0);
      end
      rnd_clr = 0;

      // Stall: CLKDV stuck low after lock.
      repeat (6) period(H, H, 1'b0);
      period(H, H, 1'b1);
      for (int i = 0; i < H; i++) step(1'b1, 1'b0);
      st_at = -1;
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 1'b0);
         if (STALL && st_at < 0) st_at = i + 1;
      end
      check("stall_at", st_at, TMO);
      check("stall_locked", LOCKED, 0);
      repeat (6) period(H, H, 1'b0);
      check("stall_relock", LOCKED, 1);
      check("stall_sticky", STALL, 1);

      // Divider reset mid-high: short high, 20 low, then resume.
      period(H, H, 1'b1);
      period(2, 20, 1'b0);
      period(H, H, 1'b0);
      check("dvrst_high", lv_high, 2);
      period(H, H, 1'b0);
      check("dvrst_locked", LOCKED, 0);
      check("dvrst_err", ERR, 1);

      // Async reset in the middle of a low phase.
      repeat (2) period(H, H, 1'b0);
      for (int i = 0; i < H; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      #2 CDRST_N = 1'b0;
      #1 check_zero("arst");
      @(posedge CLKIN);
      @(negedge CLKIN);
      #2 CDRST_N = 1'b1;
      model_reset();
      k = 0;
      first_vld = -1;
      repeat (3) step(1'b0, 1'b0);
      repeat (2) period(H, H, 1'b0);
      check("arst_first_vld", first_vld, 14);

      // Bad period while locked with ERR_CLR in the same cycle.
      repeat (5) period(H, H, 1'b0);
      check("simul_pre_lock", LOCKED, 1);
      period(6, 4, 1'b0);
      period(H, H, 1'b1);
      check("simul_err", ERR, 1);
`ifdef CLK_DIV_MONITOR_ERRCNT_EN
      check("simul_ecnt", ERR_COUNT, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
